// File: rtl/lsu_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl_if
// Data-memory port between the load/store bus controller and the memory.
// Signal suffixes are named from the controller's point of view.
//   dmem_req_out   - bus request, held high for the whole transaction
//   dmem_we_out    - 1 = write, 0 = read
//   dmem_addr_out  - word-aligned address
//   dmem_wdata_out - lane-replicated store data
//   dmem_wmask_out - byte enables (0000 on reads)
//   dmem_ack_in    - completion from memory
//   dmem_rdata_in  - read data, valid with dmem_ack_in
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface lsu_bus_ctrl_if;
   logic        dmem_req_out;
   logic        dmem_we_out;
   logic [31:0] dmem_addr_out;
   logic [31:0] dmem_wdata_out;
   logic [3:0]  dmem_wmask_out;
   logic        dmem_ack_in;
   logic [31:0] dmem_rdata_in;

   modport master (
      output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out,
      input  dmem_ack_in, dmem_rdata_in
   );

   modport slave (
      input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out,
      output dmem_ack_in, dmem_rdata_in
   );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl
// Load/store bus controller for the STRV32I core. Accepts a load or store
// from the decoder, runs one registered req/ack transaction on the data
// memory port, stalls the pipeline meanwhile, and returns sign/zero-extended
// load data. Misaligned accesses are rejected without a bus cycle; a missing
// ack is turned into a bus error after TIMEOUT_CYCLES busy cycles.
// Ports:
//   clk_in, rst_in      - clock, asynchronous active-low reset
//   ld_req_in/st_req_in - load / store request (store wins if both)
//   size_in             - 00 byte, 01 half, 10/11 word
//   unsigned_in         - zero-extend loads
//   addr_in, st_data_in - effective address, store data
//   dmem                - data-memory port (master side)
//   stall_out           - combinational pipeline hold
//   load_data_out       - extended load result, held until the next load
//   load_valid_out, st_done_out, misaligned_out, bus_err_out
//                       - one-cycle completion pulses, exactly one per access
// ---------------------------------------------------------------------------
module lsu_bus_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  ld_req_in,
   input  logic                  st_req_in,
   input  logic [1:0]            size_in,
   input  logic                  unsigned_in,
   input  logic [31:0]           addr_in,
   input  logic [31:0]           st_data_in,
   lsu_bus_ctrl_if.master        dmem,
   output logic                  stall_out,
   output logic [31:0]           load_data_out,
   output logic                  load_valid_out,
   output logic                  st_done_out,
   output logic                  misaligned_out,
   output logic                  bus_err_out
);

   localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] busy_cnt;
   logic [1:0]       size_q;
   logic             uns_q;
   logic [1:0]       lane_q;

   logic             req_any;
   logic             misaligned;
   logic [3:0]       wmask_c;
   logic [31:0]      wdata_c;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [31:0]      ld_ext;
   logic [CNT_W-1:0] cnt_inc;
   logic             timeout_hit;

   assign req_any    = ld_req_in | st_req_in;
   assign misaligned = ((size_in == 2'b01) & addr_in[0]) |
                       (size_in[1] & (addr_in[1:0] != 2'b00));
   assign stall_out  = ((state == IDLE) & req_any) | (state == BUSY);

   assign cnt_inc     = busy_cnt + CNT_W'(1);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL);

   // Store lane replication and byte enables; reads never enable a byte.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // branch, so no path leaves it unassigned and no latch is inferred.
      wmask_c = 4'b1111;
      wdata_c = st_data_in;
      case (size_in)
         2'b00: begin
            wmask_c = 4'b0001 << addr_in[1:0];
            wdata_c = {4{st_data_in[7:0]}};
         end
         2'b01: begin
            wmask_c = 4'b0011 << {addr_in[1], 1'b0};
            wdata_c = {2{st_data_in[15:0]}};
         end
         default: ;
      endcase
      if (!st_req_in) wmask_c = 4'b0000;
   end

   // Lane select and extension of the returned read data.
   always_comb begin
      rd_byte = dmem.dmem_rdata_in[7:0];
      case (lane_q)
         2'd1:    rd_byte = dmem.dmem_rdata_in[15:8];
         2'd2:    rd_byte = dmem.dmem_rdata_in[23:16];
         2'd3:    rd_byte = dmem.dmem_rdata_in[31:24];
         default: ;
      endcase
      rd_half = lane_q[1] ? dmem.dmem_rdata_in[31:16] : dmem.dmem_rdata_in[15:0];
      case (size_q)
         2'b00:   ld_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
         2'b01:   ld_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
         default: ld_ext = dmem.dmem_rdata_in;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state               <= IDLE;
         busy_cnt            <= '0;
         size_q              <= 2'b00;
         uns_q               <= 1'b0;
         lane_q              <= 2'b00;
         dmem.dmem_req_out   <= 1'b0;
         dmem.dmem_we_out    <= 1'b0;
         dmem.dmem_addr_out  <= 32'h0;
         dmem.dmem_wdata_out <= 32'h0;
         dmem.dmem_wmask_out <= 4'b0000;
         load_data_out       <= 32'h0;
         load_valid_out      <= 1'b0;
         st_done_out         <= 1'b0;
         misaligned_out      <= 1'b0;
         bus_err_out         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only in clocked logic; the pulse
         // defaults below are overridden by a later assignment in the same
         // cycle, which is what makes each pulse exactly one cycle wide.
         load_valid_out <= 1'b0;
         st_done_out    <= 1'b0;
         misaligned_out <= 1'b0;
         bus_err_out    <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  if (misaligned) begin
                     misaligned_out <= 1'b1;
                     state          <= DONE;
                  end else begin
                     dmem.dmem_req_out   <= 1'b1;
                     dmem.dmem_we_out    <= st_req_in;
                     dmem.dmem_addr_out  <= {addr_in[31:2], 2'b00};
                     dmem.dmem_wdata_out <= wdata_c;
                     dmem.dmem_wmask_out <= wmask_c;
                     size_q              <= size_in;
                     uns_q               <= unsigned_in;
                     lane_q              <= addr_in[1:0];
                     busy_cnt            <= '0;
                     state               <= BUSY;
                  end
               end
            end
            BUSY: begin
               // An ack in the final allowed cycle still completes normally.
               if (dmem.dmem_ack_in) begin
                  dmem.dmem_req_out <= 1'b0;
                  state             <= DONE;
                  if (dmem.dmem_we_out) begin
                     st_done_out <= 1'b1;
                  end else begin
                     load_valid_out <= 1'b1;
                     load_data_out  <= ld_ext;
                  end
               end else if (timeout_hit) begin
                  dmem.dmem_req_out <= 1'b0;
                  bus_err_out       <= 1'b1;
                  state             <= DONE;
               end else begin
                  busy_cnt <= cnt_inc;
               end
            end
            // Requests are ignored here so the stalled instruction retires
            // on this cycle's edge without being issued a second time.
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lsu_bus_ctrl.md
# lsu_bus_ctrl

Load/store bus controller for the STRV32I core. It sits directly downstream of the instruction decoder and consumes its memory-control outputs: store request, load size, and load-unsigned flag. It runs a registered request/acknowledge transaction on the data-memory port and stalls the pipeline while the transaction is in flight. It returns byte/half/word load data, sign- or zero-extended and ready for writeback, and flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16 — maximum cycles spent in BUSY waiting for an ack; 0 disables the timeout.

Ports:
- clk_in  input  1  — single clock; all state updates on the rising edge.
- rst_in  input  1  — asynchronous, active-low reset.
- ld_req_in  input  1  — current instruction is a load.
- st_req_in  input  1  — current instruction is a store (the decoder's store request).
- size_in  input  2  — access size: 00 byte, 01 half, 10 word, 11 treated as word (the decoder's load size).
- unsigned_in  input  1  — zero-extend the load when 1 (the decoder's load-unsigned flag).
- addr_in  input  32  — effective address from the address adder.
- st_data_in  input  32  — store source register value.
- dmem_req_out  output  1  — bus request; registered.
- dmem_we_out  output  1  — 1 = write, 0 = read.
- dmem_addr_out  output  32  — word-aligned address {addr[31:2],2'b00}.
- dmem_wdata_out  output  32  — lane-replicated store data.
- dmem_wmask_out  output  4  — byte-enable mask; 0000 on reads.
- dmem_ack_in  input  1  — bus completion, sampled only while dmem_req_out = 1.
- dmem_rdata_in  input  32  — read data, valid in the cycle dmem_ack_in = 1.
- stall_out  output  1  — combinational pipeline hold.
- load_data_out  output  32  — extended load result; holds its value until the next load completes.
- load_valid_out  output  1  — one-cycle pulse: load done.
- st_done_out  output  1  — one-cycle pulse: store done.
- misaligned_out  output  1  — one-cycle pulse: access rejected.
- bus_err_out  output  1  — one-cycle pulse: timeout.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE, no request:** the block stays in IDLE.
- **IDLE, request present:** a request is ld_req_in | st_req_in.
  - If both are asserted, the store wins and the load is ignored.
  - Misaligned accesses are half with addr[0]=1 and word with addr[1:0]≠00. These issue no bus cycle: the block latches the misaligned flag and goes to DONE.
  - Otherwise the block latches addr, we, size, unsigned, addr[1:0], wdata and wmask, sets dmem_req_out, and goes to BUSY.
- **Write mask and data:**
  - Byte: mask = 0001<<addr[1:0]; data = {4{d[7:0]}}.
  - Half: mask = 0011<<{addr[1],0}; data = {2{d[15:0]}}.
  - Word: mask = 1111; data = d.
- **BUSY:** all dmem_* outputs are held stable.
  - On dmem_ack_in=1: clear req and go to DONE.
    - For a load, capture the selected lane of dmem_rdata_in, extended per the latched unsigned flag.
    - Lane select: byte uses rdata[8*a+7:8*a]; half uses rdata[16*a1+15:16*a1].
  - If TIMEOUT_CYCLES≠0 and the BUSY cycle counter reaches TIMEOUT_CYCLES with no ack: clear req, latch the bus-error flag, and go to DONE. The counter is 5 bits, or sized by $clog2(TIMEOUT_CYCLES+1).
- **DONE:** exactly one cycle long.
  - Exactly one pulse fires: load_valid_out, st_done_out, misaligned_out, or bus_err_out.
  - Requests are ignored, so the stalled instruction retires without re-issue. The next state is always IDLE.
- **stall_out** = (IDLE & (ld_req_in|st_req_in)) | BUSY. It is 0 in DONE.
- **Reset values:** dmem_req_out=0, dmem_we_out=0, dmem_addr_out=0, dmem_wdata_out=0, dmem_wmask_out=0, load_data_out=0, all pulses 0, state=IDLE, counter=0.

## Timing
- Best-case transaction, with the request accepted at cycle T0:
  - T0: stall_out=1 (combinational).
  - T1: dmem_req_out=1. An ack at T1 moves the state to DONE at T2.
  - T2: load_valid_out=1, stall_out=0, and load_data_out is valid. The pipeline advances on the T2 edge.
- Occupancy is 3 + (ack wait) cycles.
- Misaligned access: stall at T0, misaligned_out=1 at T1, no dmem_req_out at any point.
- Timeout: the error is declared after TIMEOUT_CYCLES BUSY cycles; bus_err_out is high in the following cycle.
- An ack arriving while dmem_req_out=0 is ignored.
- Reset asserted mid-BUSY drops dmem_req_out immediately (asynchronous) and produces no completion pulse.
- The bus must not see a second request before DONE; consecutive memory instructions are spaced by at least one IDLE evaluation.

## Test plan
- **LW, aligned:** addr=0x100, ack one cycle after req, rdata=0xDEADBEEF → dmem_addr_out=0x100, wmask=0000, load_data_out=0xDEADBEEF, load_valid_out pulses at T2.
- **LB / LBU:** addr=0x103, rdata=0x80FF_0000.
  - LB → load_data_out=0xFFFFFF80.
  - LBU → load_data_out=0x00000080.
- **SH:** addr=0x202, st_data=0x1234ABCD → dmem_addr_out=0x200, wmask=1100, wdata=0xABCDABCD, we=1, st_done_out pulse.
- **Misaligned LW:** addr=0x101 → dmem_req_out stays 0, misaligned_out pulses 1 cycle, stall_out is 1 for exactly 1 cycle.
- **Timeout:** TIMEOUT_CYCLES=4, no ack → req drops after 4 BUSY cycles, bus_err_out pulses, and a late ack is ignored.
- **Simultaneous ld+st, then reset mid-BUSY:**
  - ld+st together → a write is issued.
  - rst_in=0 during BUSY → dmem_req_out=0 immediately and no completion pulse.
  - After release, a new LW completes normally.
